pwm_duty_monitor: RTL

//   Checker stage directly downstream of the per-channel PWM generator.

---
 rtl/pwm_duty_monitor.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pwm_duty_monitor.sv
// pwm_duty_monitor
//   Checker stage behind the per-channel PWM generator. The block counts the
//   high cycles of every channel over a fixed window of WIN clocks. At the end
//   of each window it captures the count and flags channels whose non-zero
//   count is more than TOL away from EXP_DUTY.
//
//   clk        system clock, posedge
//   rst        synchronous active-high reset
//   pwm_in     [N_CH]  generator PWM outputs
//   enable     1 = run back-to-back windows, 0 = abort and idle
//   fault_clr  clears the sticky fault bits (a set on the same cycle wins)
//   sel_ch     [8]     channel selected for the read port (>= N_CH reads 0)
//   sel_count  [CW]    last captured count of sel_ch, one cycle latency
//   fault      [N_CH]  sticky per-channel fault flags
//   win_done   one-cycle pulse after each completed window capture
module pwm_duty_monitor #(
  parameter int unsigned N_CH     = 256,
  parameter int unsigned WIN      = 101,
  parameter int unsigned CW       = 8,
  parameter int unsigned EXP_DUTY = 20,
  parameter int unsigned TOL      = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] pwm_in,
  input  logic            enable,
  input  logic            fault_clr,
  input  logic [7:0]      sel_ch,
  output logic [CW-1:0]   sel_count,
  output logic [N_CH-1:0] fault,
  output logic            win_done
);

  localparam int unsigned WCW = $clog2(WIN);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [WCW-1:0]  wcnt;
  logic [CW-1:0]   hcnt   [N_CH];
  logic [CW-1:0]   result [N_CH];
  logic [CW-1:0]   sum    [N_CH];
  logic [N_CH-1:0] new_fault;
  logic            run;
  logic            win_end;

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic b);
    logic [CW:0] s;
    s = {1'b0, a} + {{CW{1'b0}}, b};
    return s[CW] ? '1 : s[CW-1:0];
  endfunction

  // A count of 0 means the channel is dark, which is not a fault.
  function automatic logic is_fault(input logic [CW-1:0] c);
    int unsigned v;
    v = 32'(c);
    return (c != '0) && ((v > EXP_DUTY + TOL) || (v + TOL < EXP_DUTY));
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable)  state_nx = MEASURE;
      MEASURE: if (!enable) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control decode. Dropping enable on the window-end cycle suppresses the
  // capture because win_end requires run.
  always_comb begin
    run     = (state == MEASURE) && enable;
    win_end = run && (wcnt == WCW'(WIN - 1));
  end

  // The running sum includes the current sample. This sum is also the captured
  // value, so the last sample of the window is counted.
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      sum[i]       = sat_add(hcnt[i], pwm_in[i]);
      new_fault[i] = win_end && is_fault(sum[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt      <= '0;
      win_done  <= 1'b0;
      fault     <= '0;
      sel_count <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        hcnt[i]   <= '0;
        result[i] <= '0;
      end
    end else begin
      win_done  <= win_end;
      fault     <= (fault_clr ? '0 : fault) | new_fault;
      sel_count <= (32'(sel_ch) < N_CH) ? result[sel_ch] : '0;
      if (win_end) begin
        wcnt <= '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
          result[i] <= sum[i];
          hcnt[i]   <= '0;
        end
      end else if (run) begin
        wcnt <= wcnt + WCW'(1);
        for (int unsigned i = 0; i < N_CH; i++) begin
          hcnt[i] <= sum[i];
        end
      end else begin
        wcnt <= '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
          hcnt[i] <= '0;
        end
      end
    end
  end

endmodule
